// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: ALU op codes, bus-select codes and the status-flag bundle.
// Imported by the ALU core and the bus/flag datapath top.
package cpu_pkg;

    typedef enum logic [2:0] {
        ALU_PASSTHROUGH = 3'd0,
        ALU_ADD         = 3'd1,
        ALU_SUB         = 3'd2,
        ALU_AND         = 3'd3,
        ALU_OR          = 3'd4,
        ALU_XOR         = 3'd5,
        ALU_SHL         = 3'd6,
        ALU_SHR         = 3'd7
    } alu_op_e;

    typedef enum logic [2:0] {
        A_OUT     = 3'd0,
        X_OUT     = 3'd1,
        Y_OUT     = 3'd2,
        MEM_OUT   = 3'd3,
        INSTR_OUT = 3'd4,
        ADDR_OUT  = 3'd5,
        PC_OUT    = 3'd6,
        UNUSED1   = 3'd7
    } bus_sel_e;

    typedef struct packed {
        logic zero;
        logic carry;
        logic sign;
        logic overflow;
    } flags_t;

    // Signed less-than as seen by the branch logic after a SUB/compare.
    function automatic logic flags_lt(input flags_t f);
        return f.sign ^ f.overflow;
    endfunction

endpackage

// File: rtl/alu_bus_datapath_if.sv
// Bus-side bundle of the execution datapath: sources, selects, operand, results and flags.
// master = controller/register side, slave = the datapath itself.
interface alu_bus_datapath_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] src_c;
    logic [WIDTH-1:0] src_d;
    logic [WIDTH-1:0] src_e;
    logic [WIDTH-1:0] src_f;
    logic [WIDTH-1:0] src_g;
    logic [WIDTH-1:0] src_h;
    logic [2:0]       bus_slct;
    logic [WIDTH-1:0] acc;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] bus;
    logic [WIDTH-1:0] alu_out;
    logic             zero;
    logic             carry;
    logic             sign;
    logic             overflow;
    logic             zero_flag;
    logic             carry_flag;
    logic             sign_flag;
    logic             overflow_flag;

    modport master (
        output src_a, src_b, src_c, src_d, src_e, src_f, src_g, src_h,
        output bus_slct, acc, alu_op,
        input  bus, alu_out, zero, carry, sign, overflow,
        input  zero_flag, carry_flag, sign_flag, overflow_flag
    );

    modport slave (
        input  src_a, src_b, src_c, src_d, src_e, src_f, src_g, src_h,
        input  bus_slct, acc, alu_op,
        output bus, alu_out, zero, carry, sign, overflow,
        output zero_flag, carry_flag, sign_flag, overflow_flag
    );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU: accumulator (a) versus bus operand (b), wrap-around result
// plus zero/carry/sign/overflow flags for the current operation.
module alu_core
    import cpu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_e          op,
    output logic [WIDTH-1:0] result,
    output flags_t           flags
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0] sum;
    logic           carry_c;
    logic           overflow_c;

    always_comb begin
        sum        = '0;
        result     = '0;
        carry_c    = 1'b0;
        overflow_c = 1'b0;
        unique case (op)
            ALU_PASSTHROUGH: result = b;
            ALU_ADD: begin
                sum        = {1'b0, a} + {1'b0, b};
                result     = sum[MSB:0];
                carry_c    = sum[WIDTH];
                overflow_c = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
            end
            ALU_SUB: begin
                // a + ~b + 1: carry-out set means no borrow (a >= b unsigned)
                sum        = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                result     = sum[MSB:0];
                carry_c    = sum[WIDTH];
                overflow_c = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SHL: begin
                result  = {b[MSB-1:0], 1'b0};
                carry_c = b[MSB];
            end
            ALU_SHR: begin
                result  = {1'b0, b[MSB:1]};
                carry_c = b[0];
            end
            default: result = b;
        endcase
    end

    always_comb begin
        flags          = '0;
        flags.zero     = (result == '0);
        flags.carry    = carry_c;
        flags.sign     = result[MSB];
        flags.overflow = overflow_c;
    end

endmodule

// File: rtl/alu_bus_datapath.sv
// CPU execution datapath slice: 8-way source mux onto the internal bus, ALU on acc/bus,
// and the registered status-flag bank (held on PASS, cleared by synchronous reset).
module alu_bus_datapath
    import cpu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic               clk,
    input logic               rst_n,
    alu_bus_datapath_if.slave io
);

    logic [WIDTH-1:0] bus_int;
    logic [WIDTH-1:0] alu_res;
    alu_op_e          op;
    flags_t           flags_c;
    flags_t           flags_q;

    assign op = alu_op_e'(io.alu_op);

    always_comb begin
        bus_int = '0;
        unique case (bus_sel_e'(io.bus_slct))
            A_OUT:     bus_int = io.src_a;
            X_OUT:     bus_int = io.src_b;
            Y_OUT:     bus_int = io.src_c;
            MEM_OUT:   bus_int = io.src_d;
            INSTR_OUT: bus_int = io.src_e;
            ADDR_OUT:  bus_int = io.src_f;
            PC_OUT:    bus_int = io.src_g;
            UNUSED1:   bus_int = io.src_h;
            default:   bus_int = '0;
        endcase
    end

    alu_core #(
        .WIDTH(WIDTH)
    ) u_alu_core (
        .a      (io.acc),
        .b      (bus_int),
        .op     (op),
        .result (alu_res),
        .flags  (flags_c)
    );

    // PASS is used for plain register loads, so it must not disturb the status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else if (op != ALU_PASSTHROUGH) begin
            flags_q <= flags_c;
        end
    end

    assign io.bus           = bus_int;
    assign io.alu_out       = alu_res;
    assign io.zero          = flags_c.zero;
    assign io.carry         = flags_c.carry;
    assign io.sign          = flags_c.sign;
    assign io.overflow      = flags_c.overflow;
    assign io.zero_flag     = flags_q.zero;
    assign io.carry_flag    = flags_q.carry;
    assign io.sign_flag     = flags_q.sign;
    assign io.overflow_flag = flags_q.overflow;

endmodule

// File: tb/tb_alu_bus_datapath.sv
// Self-checking bench for alu_bus_datapath: directed vector table, multi-cycle
// flag/reset sequences and random stimulus against an arithmetic reference model.
module tb_alu_bus_datapath;
    import cpu_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_bus_datapath_if #(.WIDTH(W)) io ();

    alu_bus_datapath #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io.slave)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] r;
        logic       z;
        logic       c;
        logic       s;
        logic       o;
    } res_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        res_t       exp;
    } vec_t;

    logic [W-1:0] srcs [8];
    logic [3:0]   flag_model;   // {z, c, s, o} as the flag bank should hold them

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model from the op definitions using integer arithmetic.
    function automatic res_t model(input int a, input int b, input int op);
        res_t res;
        int sa, sb, full, sfull;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        full = 0;
        res.c = 1'b0;
        res.o = 1'b0;
        case (op)
            1: begin
                full  = a + b;
                sfull = sa + sb;
                res.c = (full > 255);
                res.o = (sfull > 127) || (sfull < -128);
            end
            2: begin
                full  = a - b + 256;
                sfull = sa - sb;
                res.c = (a >= b);
                res.o = (sfull > 127) || (sfull < -128);
            end
            3: full = a & b;
            4: full = a | b;
            5: full = a ^ b;
            6: begin
                full  = b * 2;
                res.c = (b >= 128);
            end
            7: begin
                full  = b / 2;
                res.c = (b % 2) == 1;
            end
            default: full = b;
        endcase
        res.r = 8'(full % 256);
        res.z = (full % 256) == 0;
        res.s = (full % 256) >= 128;
        return res;
    endfunction

    task automatic apply(input logic [7:0] a, input logic [2:0] sel, input logic [2:0] op,
                         input res_t exp, input string tag);
        @(negedge clk);
        io.src_a    = srcs[0];
        io.src_b    = srcs[1];
        io.src_c    = srcs[2];
        io.src_d    = srcs[3];
        io.src_e    = srcs[4];
        io.src_f    = srcs[5];
        io.src_g    = srcs[6];
        io.src_h    = srcs[7];
        io.acc      = a;
        io.bus_slct = sel;
        io.alu_op   = op;
        #1;
        check({tag, "/bus"},      32'(io.bus),      32'(srcs[sel]));
        check({tag, "/alu_out"},  32'(io.alu_out),  32'(exp.r));
        check({tag, "/zero"},     32'(io.zero),     32'(exp.z));
        check({tag, "/carry"},    32'(io.carry),    32'(exp.c));
        check({tag, "/sign"},     32'(io.sign),     32'(exp.s));
        check({tag, "/overflow"}, 32'(io.overflow), 32'(exp.o));
        @(posedge clk);
        #1;
        if (!rst_n)       flag_model = '0;
        else if (op != 0) flag_model = {exp.z, exp.c, exp.s, exp.o};
        check({tag, "/zero_flag"},     32'(io.zero_flag),     32'(flag_model[3]));
        check({tag, "/carry_flag"},    32'(io.carry_flag),    32'(flag_model[2]));
        check({tag, "/sign_flag"},     32'(io.sign_flag),     32'(flag_model[1]));
        check({tag, "/overflow_flag"}, 32'(io.overflow_flag), 32'(flag_model[0]));
    endtask

    vec_t vecs [14];

    initial begin
        // {a, b (on MEM_OUT), op, {r, z, c, s, o}}
        vecs[0]  = '{8'h7F, 8'h01, 3'd1, '{8'h80, 0, 0, 1, 1}};
        vecs[1]  = '{8'h00, 8'h00, 3'd0, '{8'h00, 1, 0, 0, 0}};
        vecs[2]  = '{8'h05, 8'h05, 3'd2, '{8'h00, 1, 1, 0, 0}};
        vecs[3]  = '{8'h03, 8'h05, 3'd2, '{8'hFE, 0, 0, 1, 0}};
        vecs[4]  = '{8'h80, 8'h01, 3'd2, '{8'h7F, 0, 1, 0, 1}};
        vecs[5]  = '{8'hFF, 8'h01, 3'd1, '{8'h00, 1, 1, 0, 0}};
        vecs[6]  = '{8'hF0, 8'h3C, 3'd3, '{8'h30, 0, 0, 0, 0}};
        vecs[7]  = '{8'hF0, 8'h0F, 3'd4, '{8'hFF, 0, 0, 1, 0}};
        vecs[8]  = '{8'hAA, 8'hAA, 3'd5, '{8'h00, 1, 0, 0, 0}};
        vecs[9]  = '{8'h00, 8'h81, 3'd6, '{8'h02, 0, 1, 0, 0}};
        vecs[10] = '{8'h00, 8'h81, 3'd7, '{8'h40, 0, 1, 0, 0}};
        vecs[11] = '{8'h00, 8'h00, 3'd7, '{8'h00, 1, 0, 0, 0}};
        vecs[12] = '{8'h7F, 8'h80, 3'd2, '{8'hFF, 0, 0, 1, 1}};
        vecs[13] = '{8'h01, 8'hFF, 3'd0, '{8'hFF, 0, 0, 1, 0}};

        rst_n = 1'b0;
        flag_model = '0;
        for (int i = 0; i < 8; i++) srcs[i] = '0;

        // Reset state
        apply(8'h00, 3'd0, 3'd0, model(0, 0, 0), "reset_state");
        rst_n = 1'b1;

        // Mux sweep
        for (int i = 0; i < 8; i++) srcs[i] = 8'((i + 1) * 8'h11);
        for (int i = 0; i < 8; i++)
            apply(8'h00, 3'(i), 3'd0, model(0, int'(srcs[i]), 0), $sformatf("mux%0d", i));

        // Directed table; operand b arrives over MEM_OUT
        for (int i = 0; i < 14; i++) begin
            srcs[3] = vecs[i].b;
            apply(vecs[i].a, 3'd3, vecs[i].op, vecs[i].exp, $sformatf("vec%0d", i));
            if (vecs[i].op == 3'd2)
                check($sformatf("vec%0d/lt", i),
                      32'(io.sign_flag ^ io.overflow_flag),
                      32'($signed(vecs[i].a) < $signed(vecs[i].b)));
        end

        // PASS holds the flags left by an overflowing ADD
        srcs[3] = 8'h01;
        apply(8'h7F, 3'd3, 3'd1, '{8'h80, 0, 0, 1, 1}, "pass_pre");
        srcs[3] = 8'h00;
        apply(8'h7F, 3'd3, 3'd0, '{8'h00, 1, 0, 0, 0}, "pass_hold");
        check("pass_hold/sign_kept", 32'(io.sign_flag), 32'd1);
        check("pass_hold/ovf_kept",  32'(io.overflow_flag), 32'd1);

        // Reset beats an ADD on the same edge; combinational outputs unaffected
        srcs[3] = 8'h01;
        rst_n = 1'b0;
        apply(8'h7F, 3'd3, 3'd1, '{8'h80, 0, 0, 1, 1}, "reset_add");
        rst_n = 1'b1;
        apply(8'hFF, 3'd3, 3'd1, '{8'h00, 1, 1, 0, 0}, "after_reset");

        // Random stimulus against the model
        for (int n = 0; n < 300; n++) begin
            logic [7:0] a;
            logic [2:0] sel, op;
            for (int i = 0; i < 8; i++) srcs[i] = 8'($urandom_range(0, 255));
            a   = 8'($urandom_range(0, 255));
            sel = 3'($urandom_range(0, 7));
            op  = 3'($urandom_range(0, 7));
            if (n % 40 == 39) rst_n = 1'b0;
            apply(a, sel, op, model(int'(a), int'(srcs[sel]), int'(op)), $sformatf("rnd%0d", n));
            rst_n = 1'b1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
